playfield_ram_arbiter: RTL and testbench

PLAYFIELD_RAM_ARBITER -- requirements
Module: playfield_ram_arbiter

---
 rtl/tetris_pkg.sv | 24 ++
 rtl/playfield_clear_seq.sv | 70 +++++++
 rtl/playfield_ram_arbiter.sv | 156 +++++++++++++++
 tb/tb_playfield_ram_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris playfield RAM path: default geometry,
// RAM owner encoding and clear sequencer states.
package tetris_pkg;

    localparam int PF_ADDR_W     = 11;
    localparam int PF_DATA_W     = 6;
    localparam int PF_CLR_VALUE  = 0;
    localparam int PF_CLR_LAST   = 2047;
    localparam int PF_STARVE_MAX = 15;

    // Who owns the RAM port in a given cycle
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_CLR  = 2'd2,
        OWN_GAME = 2'd3
    } owner_t;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

endpackage

// File: rtl/playfield_clear_seq.sv
// Full-field clear sequencer: walks addresses 0..CLR_LAST, advancing only
// when the arbiter hands it a RAM slot.
//
// state    | meaning
// ---------+----------------------------------------------------------
// CLR_IDLE | no clear running; clr_start loads address 0 and starts
// CLR_RUN  | clearing; clr_start ignored; advance on each granted slot
module playfield_clear_seq
    import tetris_pkg::*;
#(
    parameter int ADDR_W   = PF_ADDR_W,
    parameter int CLR_LAST = PF_CLR_LAST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_start,
    input  logic              clr_adv,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] clr_addr
);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;

    // Next-state: start, advance, and terminate after the last address write
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                if (clr_start) begin
                    state_d = CLR_RUN;
                    addr_d  = '0;
                end
            end
            CLR_RUN: begin
                if (clr_adv) begin
                    if (addr_q == ADDR_W'(CLR_LAST)) begin
                        state_d = CLR_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    // State register; reset aborts any clear without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLR_IDLE;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    assign clr_busy = (state_q == CLR_RUN);
    assign clr_done = done_q;
    assign clr_addr = addr_q;

endmodule

// File: rtl/playfield_ram_arbiter.sv
// Single-port playfield RAM arbiter: VGA reads > clear writes > game
// accesses, with a starvation escape that lets the game steal one clear
// slot. RAM command is registered; read data returns one cycle later and is
// tagged by a two-stage owner pipeline.
module playfield_ram_arbiter
    import tetris_pkg::*;
#(
    parameter int ADDR_W     = PF_ADDR_W,
    parameter int DATA_W     = PF_DATA_W,
    parameter int CLR_VALUE  = PF_CLR_VALUE,
    parameter int CLR_LAST   = PF_CLR_LAST,
    parameter int STARVE_MAX = PF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              game_req,
    input  logic              game_we,
    input  logic [ADDR_W-1:0] game_addr,
    input  logic [DATA_W-1:0] game_wdata,
    output logic              game_gnt,
    output logic              game_rvalid,
    output logic [DATA_W-1:0] game_rdata,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                ram_we_q, ram_we_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                game_gnt_q, game_gnt_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    owner_t              owner_d;
    owner_t              owner_s1_q, owner_s1_d;
    owner_t              owner_s2_q, owner_s2_d;
    logic                we_s2_q, we_s2_d;

    logic              game_elig;
    logic              starved;
    logic              clr_adv;
    logic [ADDR_W-1:0] clr_addr;

    playfield_clear_seq #(
        .ADDR_W   (ADDR_W),
        .CLR_LAST (CLR_LAST)
    ) u_clear_seq (
        .clk       (clk),
        .rst_n     (rst),
        .clr_start (clr_start),
        .clr_adv   (clr_adv),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .clr_addr  (clr_addr)
    );

    // Owner selection and the RAM command it produces
    always_comb begin
        // A request is not re-eligible in the grant cycle, capping the game
        // at one access every two cycles.
        game_elig = game_req && !game_gnt_q;
        starved   = clr_busy && game_elig && (starve_q >= STARVE_W'(STARVE_MAX));

        if (vga_req) begin
            owner_d = OWN_VGA;
        end else if (clr_busy && !starved) begin
            owner_d = OWN_CLR;
        end else if (game_elig) begin
            owner_d = OWN_GAME;
        end else begin
            owner_d = OWN_IDLE;
        end

        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        case (owner_d)
            OWN_VGA: begin
                ram_addr_d = vga_addr;
            end
            OWN_CLR: begin
                ram_addr_d  = clr_addr;
                ram_we_d    = 1'b1;
                ram_wdata_d = DATA_W'(CLR_VALUE);
            end
            OWN_GAME: begin
                ram_addr_d = game_addr;
                ram_we_d   = game_we;
                if (game_we) begin
                    ram_wdata_d = game_wdata;
                end
            end
            default: ;
        endcase

        clr_adv    = (owner_d == OWN_CLR);
        game_gnt_d = (owner_d == OWN_GAME);

        // Saturating wait counter; any cycle the game is not waiting clears it
        if (game_elig && (owner_d != OWN_GAME)) begin
            if (starve_q >= STARVE_W'(STARVE_MAX)) begin
                starve_d = starve_q;
            end else begin
                starve_d = starve_q + STARVE_W'(1);
            end
        end else begin
            starve_d = '0;
        end

        owner_s1_d = owner_d;
        owner_s2_d = owner_s1_q;
        we_s2_d    = ram_we_q;
    end

    // Registered RAM command, grant, starvation counter and owner pipeline
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            game_gnt_q  <= 1'b0;
            starve_q    <= '0;
            owner_s1_q  <= OWN_IDLE;
            owner_s2_q  <= OWN_IDLE;
            we_s2_q     <= 1'b0;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            game_gnt_q  <= game_gnt_d;
            starve_q    <= starve_d;
            owner_s1_q  <= owner_s1_d;
            owner_s2_q  <= owner_s2_d;
            we_s2_q     <= we_s2_d;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_we      = ram_we_q;
    assign ram_wdata   = ram_wdata_q;
    assign game_gnt    = game_gnt_q;
    assign vga_rvalid  = (owner_s2_q == OWN_VGA);
    assign game_rvalid = (owner_s2_q == OWN_GAME) && !we_s2_q;
    assign vga_rdata   = ram_rdata;
    assign game_rdata  = ram_rdata;

endmodule

// File: tb/tb_playfield_ram_arbiter.sv
// Directed bench for the playfield RAM arbiter with a behavioural RAM that
// preloads a known pattern while reset is low.
module tb_playfield_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vga_req = 1'b0;
    logic [10:0] vga_addr = '0;
    logic        vga_rvalid;
    logic [5:0]  vga_rdata;
    logic        game_req = 1'b0;
    logic        game_we = 1'b0;
    logic [10:0] game_addr = '0;
    logic [5:0]  game_wdata = '0;
    logic        game_gnt;
    logic        game_rvalid;
    logic [5:0]  game_rdata;
    logic        clr_start = 1'b0;
    logic        clr_busy;
    logic        clr_done;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [5:0]  ram_wdata;
    logic [5:0]  ram_rdata;

    logic [5:0]  mem [0:2047];

    int n_chk = 0;
    int n_err = 0;

    playfield_ram_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .vga_req     (vga_req),
        .vga_addr    (vga_addr),
        .vga_rvalid  (vga_rvalid),
        .vga_rdata   (vga_rdata),
        .game_req    (game_req),
        .game_we     (game_we),
        .game_addr   (game_addr),
        .game_wdata  (game_wdata),
        .game_gnt    (game_gnt),
        .game_rvalid (game_rvalid),
        .game_rdata  (game_rdata),
        .clr_start   (clr_start),
        .clr_busy    (clr_busy),
        .clr_done    (clr_done),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always #20 clk = ~clk;

    function automatic logic [5:0] pat(input int a);
        return 6'((a * 5 + 1) % 64);
    endfunction

    // Synchronous RAM, one-cycle read latency, preloaded during reset
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2048; i++) mem[i] <= pat(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_gnt(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (game_gnt) begin
                lat = i;
                break;
            end
        end
    endtask

    function automatic int nonzero_cells();
        int n = 0;
        for (int i = 0; i < 2048; i++) if (mem[i] != 6'd0) n++;
        return n;
    endfunction

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_ram_addr"},    int'(ram_addr),    0);
        chk({pfx, "_ram_we"},      int'(ram_we),      0);
        chk({pfx, "_ram_wdata"},   int'(ram_wdata),   0);
        chk({pfx, "_game_gnt"},    int'(game_gnt),    0);
        chk({pfx, "_game_rvalid"}, int'(game_rvalid), 0);
        chk({pfx, "_vga_rvalid"},  int'(vga_rvalid),  0);
        chk({pfx, "_clr_busy"},    int'(clr_busy),    0);
        chk({pfx, "_clr_done"},    int'(clr_done),    0);
    endtask

    initial begin
        int lat, busy_n, done_n, done_at, gnt_n, last_gnt, bad_iv;
        int found, quiet, exp_addr, seq_err;

        // Reset values
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        rst = 1'b1;
        @(negedge clk);

        // VGA burst over addresses 0..7 with a game read held pending
        vga_req   = 1'b1;
        vga_addr  = 11'd0;
        game_req  = 1'b1;
        game_we   = 1'b0;
        game_addr = 11'h010;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            chk("vga_rvalid", int'(vga_rvalid), (k >= 2 && k <= 9) ? 1 : 0);
            if (k >= 2 && k <= 9) chk("vga_rdata", int'(vga_rdata), int'(pat(k - 2)));
            chk("vga_game_gnt", int'(game_gnt), (k == 9) ? 1 : 0);
            chk("vga_game_rvalid", int'(game_rvalid), (k == 10) ? 1 : 0);
            if (k == 10) chk("vga_game_rdata", int'(game_rdata), int'(pat(16)));
            vga_addr = 11'(k);
            vga_req  = (k < 8);
            if (k == 9) game_req = 1'b0;
        end

        // Game write 0x123 <= 0x2A, then read it back
        game_req   = 1'b1;
        game_we    = 1'b1;
        game_addr  = 11'h123;
        game_wdata = 6'h2A;
        wait_gnt(lat);
        chk("wr_gnt_lat", lat, 1);
        chk("wr_ram_we", int'(ram_we), 1);
        chk("wr_ram_addr", int'(ram_addr), 'h123);
        chk("wr_ram_wdata", int'(ram_wdata), 'h2A);
        game_req = 1'b0;
        @(negedge clk);
        chk("wr_gnt_pulse", int'(game_gnt), 0);
        chk("wr_no_rvalid", int'(game_rvalid), 0);
        game_req = 1'b1;
        game_we  = 1'b0;
        wait_gnt(lat);
        chk("rd_gnt_lat", lat, 1);
        chk("rd_ram_we", int'(ram_we), 0);
        game_req = 1'b0;
        @(negedge clk);
        chk("rd_rvalid", int'(game_rvalid), 1);
        chk("rd_rdata", int'(game_rdata), 'h2A);
        @(negedge clk);
        chk("rd_rvalid_end", int'(game_rvalid), 0);
        chk("idle_ram_we", int'(ram_we), 0);
        chk("idle_ram_addr_hold", int'(ram_addr), 'h123);

        // Clear with no other traffic
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        busy_n = 0; done_n = 0; done_at = 0;
        for (int i = 1; i <= 2060; i++) begin
            if (clr_busy) busy_n++;
            if (clr_done) begin done_n++; done_at = i; end
            @(negedge clk);
        end
        chk("clr_busy_cycles", busy_n, 2048);
        chk("clr_done_count", done_n, 1);
        chk("clr_done_cycle", done_at, 2049);
        chk("clr_cells_nonzero", nonzero_cells(), 0);

        // Clear against a continuously requesting game
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        clr_start = 1'b1;
        game_req  = 1'b1;
        game_we   = 1'b0;
        game_addr = 11'd5;
        gnt_n = 0; last_gnt = 0; bad_iv = 0; done_at = 0;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk);
            clr_start = 1'b0;
            if (game_gnt) begin
                gnt_n++;
                if (last_gnt != 0 && (i - last_gnt) != 17) bad_iv++;
                last_gnt = i;
            end
            if (clr_done) begin done_at = i; break; end
        end
        game_req = 1'b0;
        chk("starve_done_cycle", done_at, 2176);
        chk("starve_gnt_count", gnt_n, 128);
        chk("starve_bad_interval", bad_iv, 0);
        @(negedge clk);
        chk("starve_cells_nonzero", nonzero_cells(), 0);

        // Reset in the middle of a clear at address 500
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            if (ram_we && ram_addr == 11'd500) begin found = 1; break; end
            @(negedge clk);
        end
        chk("abort_reached_500", found, 1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b1;
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (clr_done || clr_busy || ram_we) quiet++;
        end
        chk("abort_quiet", quiet, 0);

        // Restart from 0; a clr_start at address 100 must be ignored
        clr_start = 1'b1;
        exp_addr = 0; seq_err = 0; done_at = 0;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk);
            clr_start = 1'b0;
            if (ram_we) begin
                if (int'(ram_addr) != exp_addr) seq_err++;
                if (ram_addr == 11'd100) clr_start = 1'b1;
                exp_addr++;
            end
            if (clr_done) begin done_at = i; break; end
        end
        chk("restart_done_seen", (done_at != 0) ? 1 : 0, 1);
        chk("restart_write_count", exp_addr, 2048);
        chk("restart_seq_errors", seq_err, 0);
        quiet = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (clr_done || clr_busy || ram_we) quiet++;
        end
        chk("restart_no_rerun", quiet, 0);
        chk("restart_cells_nonzero", nonzero_cells(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
